// File: rtl/alu_ctrl_sequencer.sv
// Registered valid/ready ALU decoder: decodes {alu_op, funct} and stalls mul/div for a set latency.
// Optional feature macro: ALU_SEQ_ILLEGAL_TRAP_EN (illegal encodings reported instead of dropped).
module alu_ctrl_sequencer #(
    parameter int unsigned FUNCT_W    = 6,
    parameter int unsigned OP_W       = 2,
    parameter int unsigned CTRL_W     = 4,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] funct,
    input  logic [OP_W-1:0]    alu_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  alu_control,
    output logic               busy,
    output logic               err_illegal
);

    localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [CTRL_W-1:0]  ctrl, ctrl_next;
    logic               rst_done;
    logic               accept;

    logic [FUNCT_W+3:0] funct_x;
    logic [3:0]         dec_code;
    logic               dec_mul, dec_div, dec_illegal;

    // Decode; funct is zero-extended so narrow funct widths still compare against 0..9.
    always_comb begin
        funct_x  = {4'b0000, funct};
        dec_code = 4'b0000;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        case (alu_op[1:0])
            2'b00: dec_code = 4'b0001;
            2'b01: dec_code = 4'b0010;
            2'b10: begin
                if (funct_x < (FUNCT_W+4)'(10)) begin
                    dec_code = funct_x[3:0] + 4'd3;
                    dec_mul  = (funct_x[3:0] == 4'd2);
                    dec_div  = (funct_x[3:0] == 4'd3);
                end
            end
            default: dec_code = 4'b0000;
        endcase
        dec_illegal = (dec_code == 4'b0000);
    end

    // in_ready is held low until the first clock after reset release.
    always_comb begin
        in_ready = 1'b0;
        if (rst_done && !flush) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                OUT:     in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign accept    = in_valid && in_ready;
    assign out_valid = (state == OUT);
    assign busy      = (state == BUSY);

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic err, err_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ctrl_next  = ctrl;
        err_next   = err;
        case (state)
            BUSY: begin
                if (cnt == '0) state_next = OUT;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            OUT: if (out_ready) state_next = IDLE;
            default: ;
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (accept) begin
            ctrl_next = CTRL_W'(dec_code);
            err_next  = dec_illegal;
            if (dec_mul) begin
                state_next = BUSY;
                cnt_next   = MUL_LOAD;
            end else if (dec_div) begin
                state_next = BUSY;
                cnt_next   = DIV_LOAD;
            end else begin
                state_next = OUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else        err <= err_next;
    end

    assign err_illegal = err;
`else
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        ctrl_next  = ctrl;
        case (state)
            BUSY: begin
                if (cnt == '0) state_next = OUT;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            OUT: if (out_ready) state_next = IDLE;
            default: ;
        endcase
        if (flush) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else if (accept && !dec_illegal) begin
            // Illegal words are consumed here; state_next is already IDLE on that path.
            ctrl_next = CTRL_W'(dec_code);
            if (dec_mul) begin
                state_next = BUSY;
                cnt_next   = MUL_LOAD;
            end else if (dec_div) begin
                state_next = BUSY;
                cnt_next   = DIV_LOAD;
            end else begin
                state_next = OUT;
            end
        end
    end

    assign err_illegal = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ctrl     <= '0;
            rst_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            ctrl     <= ctrl_next;
            rst_done <= 1'b1;
        end
    end

    assign alu_control = ctrl;

endmodule
